// File: rtl/cam_capture_pkg.sv
// rtl/cam_capture_pkg.sv - shared state encoding, size defaults and pixel field layout for cam_capture
package cam_capture_pkg;

    // Capture FSM states
    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_FRAME,
        S_BYTE1,
        S_BYTE2
    } cam_state_e;

    // Default frame geometry
    localparam int H_PIX_DEF = 160;
    localparam int V_PIX_DEF = 120;
    localparam int AW_DEF    = 15;

    // 12-bit stored pixel layout {R[3:0], G[3:0], B[3:0]}
    localparam int PX_W     = 12;
    localparam int PX_CH_W  = 4;
    localparam int PX_R_LSB = 8;
    localparam int PX_G_LSB = 4;
    localparam int PX_B_LSB = 0;

endpackage

// File: rtl/cam_px_pack.sv
// rtl/cam_px_pack.sv - combinational camera byte pair to 12-bit RGB444 pixel conversion
//
// Ports:
//   byte1_i  [7:0]  first byte of the pixel pair
//   byte2_i  [7:0]  second byte of the pixel pair
//   pixel_o  [11:0] packed {R[3:0], G[3:0], B[3:0]}
//
// Build option: CAM_RGB565_EN selects RGB565 input decoding; otherwise the
// bytes are taken as RGB444 (byte1 low nibble = R, byte2 = {G, B}).
module cam_px_pack
    import cam_capture_pkg::*;
(
    input  logic [7:0]      byte1_i,
    input  logic [7:0]      byte2_i,
    output logic [PX_W-1:0] pixel_o
);

    logic [PX_CH_W-1:0] red;
    logic [PX_CH_W-1:0] green;
    logic [PX_CH_W-1:0] blue;
    logic               unused_bits;

    always_comb begin
`ifdef CAM_RGB565_EN
        // Keep the top 4 bits of each RGB565 channel
        red         = byte1_i[7:4];
        green       = {byte1_i[2:0], byte2_i[7]};
        blue        = byte2_i[4:1];
        unused_bits = ^{byte1_i[3], byte2_i[6:5], byte2_i[0]};
`else
        red         = byte1_i[3:0];
        green       = byte2_i[7:4];
        blue        = byte2_i[3:0];
        unused_bits = ^byte1_i[7:4];
`endif
        pixel_o                        = '0;
        pixel_o[PX_R_LSB +: PX_CH_W]   = red;
        pixel_o[PX_G_LSB +: PX_CH_W]   = green;
        pixel_o[PX_B_LSB +: PX_CH_W]   = blue;
    end

endmodule

// File: rtl/cam_capture.sv
// rtl/cam_capture.sv - camera byte stream capture into a dual-port frame buffer
//
// Ports:
//   CAM_pclk        sole clock, rising edge
//   rst             asynchronous active-low reset
//   CAM_vsync       frame sync, high = blanking
//   CAM_href        line valid
//   CAM_px_data     camera byte
//   DP_RAM_addr_in  write address (row*H_PIX + col), held between strobes
//   DP_RAM_data_in  12-bit pixel, held between strobes
//   DP_RAM_regW     one-cycle write strobe
//   frame_done      one-cycle pulse at frame end (at least one line seen)
//   line_err        one-cycle pulse on odd-length, oversize or aborted line
//
// Build option: CAM_RGB565_EN (see cam_px_pack) selects RGB565 decoding.
module cam_capture
    import cam_capture_pkg::*;
#(
    parameter int H_PIX = H_PIX_DEF,
    parameter int V_PIX = V_PIX_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          CAM_pclk,
    input  logic          rst,
    input  logic          CAM_vsync,
    input  logic          CAM_href,
    input  logic [7:0]    CAM_px_data,
    output logic [AW-1:0] DP_RAM_addr_in,
    output logic [11:0]   DP_RAM_data_in,
    output logic          DP_RAM_regW,
    output logic          frame_done,
    output logic          line_err
);

    // Counters saturate at H_PIX / V_PIX so they never wrap
    localparam int CW = $clog2(H_PIX + 1);
    localparam int RW = $clog2(V_PIX + 1);

    localparam logic [CW-1:0] COL_MAX   = CW'(H_PIX);
    localparam logic [RW-1:0] ROW_MAX   = RW'(V_PIX);
    localparam logic [AW-1:0] LINE_STEP = AW'(H_PIX);

    cam_state_e      state_q;
    logic [CW-1:0]   col_q;
    logic [RW-1:0]   row_q;
    logic [AW-1:0]   base_q;      // row_q * H_PIX, kept incrementally
    logic [7:0]      byte1_q;
    logic            oversize_q;  // current line produced a pixel past H_PIX
    logic [AW-1:0]   addr_q;
    logic [PX_W-1:0] data_q;
    logic            regw_q;
    logic            frame_done_q;
    logic            line_err_q;

    logic [PX_W-1:0] pixel;
    logic            col_ok;
    logic            row_ok;

    assign col_ok = (col_q < COL_MAX);
    assign row_ok = (row_q < ROW_MAX);

    cam_px_pack u_px_pack (
        .byte1_i (byte1_q),
        .byte2_i (CAM_px_data),
        .pixel_o (pixel)
    );

    always_ff @(posedge CAM_pclk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            base_q       <= '0;
            byte1_q      <= '0;
            oversize_q   <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            regw_q       <= 1'b0;
            frame_done_q <= 1'b0;
            line_err_q   <= 1'b0;
        end else begin
            regw_q       <= 1'b0;
            frame_done_q <= 1'b0;
            line_err_q   <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (CAM_vsync) begin
                        state_q <= S_VSYNC;
                    end
                end

                S_VSYNC: begin
                    col_q      <= '0;
                    row_q      <= '0;
                    base_q     <= '0;
                    oversize_q <= 1'b0;
                    if (!CAM_vsync) begin
                        state_q <= S_FRAME;
                    end
                end

                S_FRAME: begin
                    if (CAM_vsync) begin
                        state_q      <= S_VSYNC;
                        frame_done_q <= (row_q != '0);
                    end else if (CAM_href) begin
                        byte1_q <= CAM_px_data;
                        state_q <= S_BYTE2;
                    end
                end

                S_BYTE1: begin
                    if (CAM_vsync) begin
                        // Frame cut off mid-line
                        state_q      <= S_VSYNC;
                        frame_done_q <= (row_q != '0);
                        line_err_q   <= 1'b1;
                    end else if (CAM_href) begin
                        byte1_q <= CAM_px_data;
                        state_q <= S_BYTE2;
                    end else begin
                        // Clean end of line; only an oversize line is flagged
                        line_err_q <= oversize_q;
                        col_q      <= '0;
                        oversize_q <= 1'b0;
                        if (row_ok) begin
                            row_q  <= row_q + 1'b1;
                            base_q <= base_q + LINE_STEP;
                        end
                        state_q <= S_FRAME;
                    end
                end

                S_BYTE2: begin
                    if (CAM_vsync) begin
                        state_q      <= S_VSYNC;
                        frame_done_q <= (row_q != '0);
                        line_err_q   <= 1'b1;
                    end else if (CAM_href) begin
                        if (col_ok && row_ok) begin
                            regw_q <= 1'b1;
                            addr_q <= base_q + AW'(col_q);
                            data_q <= pixel;
                        end
                        if (col_ok) begin
                            col_q <= col_q + 1'b1;
                        end else begin
                            oversize_q <= 1'b1;
                        end
                        state_q <= S_BYTE1;
                    end else begin
                        // Odd byte count: drop the lone byte and close the line
                        line_err_q <= 1'b1;
                        col_q      <= '0;
                        oversize_q <= 1'b0;
                        if (row_ok) begin
                            row_q  <= row_q + 1'b1;
                            base_q <= base_q + LINE_STEP;
                        end
                        state_q <= S_FRAME;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign DP_RAM_addr_in = addr_q;
    assign DP_RAM_data_in = data_q;
    assign DP_RAM_regW    = regw_q;
    assign frame_done     = frame_done_q;
    assign line_err       = line_err_q;

endmodule

// File: tb/tb_cam_capture.sv
// tb/tb_cam_capture.sv - self-checking bench for cam_capture (vector table plus frame sequences)
module tb_cam_capture;

    logic        CAM_pclk;
    logic        rst;
    logic        CAM_vsync;
    logic        CAM_href;
    logic [7:0]  CAM_px_data;
    logic [14:0] DP_RAM_addr_in;
    logic [11:0] DP_RAM_data_in;
    logic        DP_RAM_regW;
    logic        frame_done;
    logic        line_err;

    cam_capture dut (
        .CAM_pclk       (CAM_pclk),
        .rst            (rst),
        .CAM_vsync      (CAM_vsync),
        .CAM_href       (CAM_href),
        .CAM_px_data    (CAM_px_data),
        .DP_RAM_addr_in (DP_RAM_addr_in),
        .DP_RAM_data_in (DP_RAM_data_in),
        .DP_RAM_regW    (DP_RAM_regW),
        .frame_done     (frame_done),
        .line_err       (line_err)
    );

    initial CAM_pclk = 1'b0;
    always #5 CAM_pclk = ~CAM_pclk;

    typedef struct {
        logic        vs;
        logic        hr;
        logic [7:0]  d;
        logic        e_w;
        logic [14:0] e_a;
        logic [11:0] e_d;
        logic        e_fd;
        logic        e_le;
    } vec_t;

    vec_t tbl[20];

    int n_checks = 0;
    int n_pass   = 0;

    logic [14:0] wa[$];
    logic [11:0] wd[$];
    int          fd_cnt = 0;
    int          le_cnt = 0;

    always @(negedge CAM_pclk) begin
        if (DP_RAM_regW) begin
            wa.push_back(DP_RAM_addr_in);
            wd.push_back(DP_RAM_data_in);
        end
        if (frame_done) fd_cnt++;
        if (line_err)   le_cnt++;
    end

    function automatic logic [11:0] px(input logic [7:0] b1, input logic [7:0] b2);
`ifdef CAM_RGB565_EN
        return {b1[7:4], b1[2:0], b2[7], b2[4:1]};
`else
        return {b1[3:0], b2[7:4], b2[3:0]};
`endif
    endfunction

    function automatic logic [7:0] byte_at(input int k);
        if (k % 2 == 0) return 8'(k * 7);
        return 8'(k * 13 + 5);
    endfunction

    function automatic vec_t mk(input logic vs, input logic hr, input logic [7:0] d,
                                input logic w, input logic [14:0] a, input logic [11:0] dd,
                                input logic fd, input logic le);
        vec_t v;
        v.vs = vs; v.hr = hr; v.d = d;
        v.e_w = w; v.e_a = a; v.e_d = dd; v.e_fd = fd; v.e_le = le;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic tick(input logic vs, input logic hr, input logic [7:0] d);
        CAM_vsync   = vs;
        CAM_href    = hr;
        CAM_px_data = d;
        @(posedge CAM_pclk);
        #1;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        fd_cnt = 0;
        le_cnt = 0;
    endtask

    // pat444: alternating 0x0F/0xF0; otherwise byte_at() pattern
    task automatic send_line(input int nbytes, input bit pat444);
        for (int k = 0; k < nbytes; k++) begin
            if (pat444) tick(1'b0, 1'b1, (k % 2 == 0) ? 8'h0F : 8'hF0);
            else        tick(1'b0, 1'b1, byte_at(k));
        end
        tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);
    endtask

    task automatic start_frame();
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);
    endtask

    logic [11:0] rgb_lit;
    logic [31:0] got;
    int          bad;
    int          idx;

    initial begin
`ifdef CAM_RGB565_EN
        rgb_lit = 12'hF0F;
`else
        rgb_lit = 12'h81F;
`endif
        tbl[0]  = mk(1, 0, 8'h00, 0, 15'd0,   12'h000,            0, 0);
        tbl[1]  = mk(0, 0, 8'h00, 0, 15'd0,   12'h000,            0, 0);
        tbl[2]  = mk(0, 1, 8'h0F, 0, 15'd0,   12'h000,            0, 0);
        tbl[3]  = mk(0, 1, 8'hF0, 1, 15'd0,   px(8'h0F, 8'hF0),   0, 0);
        tbl[4]  = mk(0, 1, 8'h12, 0, 15'd0,   px(8'h0F, 8'hF0),   0, 0);
        tbl[5]  = mk(0, 1, 8'h34, 1, 15'd1,   px(8'h12, 8'h34),   0, 0);
        tbl[6]  = mk(0, 0, 8'h00, 0, 15'd1,   px(8'h12, 8'h34),   0, 0);
        tbl[7]  = mk(0, 1, 8'hA5, 0, 15'd1,   px(8'h12, 8'h34),   0, 0);
        tbl[8]  = mk(0, 1, 8'h5A, 1, 15'd160, px(8'hA5, 8'h5A),   0, 0);
        tbl[9]  = mk(0, 1, 8'h77, 0, 15'd160, px(8'hA5, 8'h5A),   0, 0);
        tbl[10] = mk(0, 0, 8'h00, 0, 15'd160, px(8'hA5, 8'h5A),   0, 1);
        tbl[11] = mk(1, 0, 8'h00, 0, 15'd160, px(8'hA5, 8'h5A),   1, 0);
        tbl[12] = mk(0, 0, 8'h00, 0, 15'd160, px(8'hA5, 8'h5A),   0, 0);
        tbl[13] = mk(0, 1, 8'hF8, 0, 15'd160, px(8'hA5, 8'h5A),   0, 0);
        tbl[14] = mk(0, 1, 8'h1F, 1, 15'd0,   rgb_lit,            0, 0);
        tbl[15] = mk(0, 0, 8'h00, 0, 15'd0,   rgb_lit,            0, 0);
        tbl[16] = mk(1, 0, 8'h00, 0, 15'd0,   rgb_lit,            1, 0);
        tbl[17] = mk(1, 0, 8'h00, 0, 15'd0,   rgb_lit,            0, 0);
        tbl[18] = mk(0, 0, 8'h00, 0, 15'd0,   rgb_lit,            0, 0);
        tbl[19] = mk(1, 0, 8'h00, 0, 15'd0,   rgb_lit,            0, 0);

        rst = 1'b0;
        CAM_vsync = 1'b0;
        CAM_href = 1'b0;
        CAM_px_data = 8'h00;
        repeat (3) @(posedge CAM_pclk);
        #1;
        chk("reset_outputs",
            {DP_RAM_regW, DP_RAM_addr_in, DP_RAM_data_in, frame_done, line_err}, 32'd0);
        rst = 1'b1;
        tick(1'b0, 1'b0, 8'h00);
        chk("idle_no_write", DP_RAM_regW, 1'b0);

        // Cycle-accurate vector table
        for (int i = 0; i < 20; i++) begin
            tick(tbl[i].vs, tbl[i].hr, tbl[i].d);
            got = {2'b0, DP_RAM_regW, DP_RAM_addr_in, DP_RAM_data_in, frame_done, line_err};
            if (got !== {2'b0, tbl[i].e_w, tbl[i].e_a, tbl[i].e_d, tbl[i].e_fd, tbl[i].e_le})
                $display("vector %0d vs=%0b hr=%0b d=%02h", i, tbl[i].vs, tbl[i].hr, tbl[i].d);
            chk($sformatf("vec%0d", i), got,
                {2'b0, tbl[i].e_w, tbl[i].e_a, tbl[i].e_d, tbl[i].e_fd, tbl[i].e_le});
        end

        // Full frame, plus one extra line beyond V_PIX that must not be written
        tick(1'b1, 1'b0, 8'h00);
        clear_log();
        tick(1'b0, 1'b0, 8'h00);
        for (int l = 0; l < 120; l++) send_line(320, 1'b1);
        chk("full_strobes", wa.size(), 19200);
        bad = 0;
        for (int i = 0; i < wa.size(); i++)
            if (wa[i] !== 15'(i) || wd[i] !== px(8'h0F, 8'hF0)) bad++;
        chk("full_addr_data", bad, 0);
        send_line(320, 1'b1);
        chk("row_limit_strobes", wa.size(), 19200);
        chk("full_no_fd_yet", fd_cnt, 0);
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 8'h00);
        chk("full_fd", fd_cnt, 1);
        chk("full_le", le_cnt, 0);

        // Lines of 320, 321, 330, 320 bytes
        clear_log();
        tick(1'b0, 1'b0, 8'h00);
        send_line(320, 1'b0);
        send_line(321, 1'b0);
        chk("odd_le", le_cnt, 1);
        send_line(330, 1'b0);
        chk("over_le", le_cnt, 2);
        send_line(320, 1'b0);
        chk("len_strobes", wa.size(), 640);
        bad = 0;
        for (int i = 0; i < wa.size(); i++) begin
            idx = i % 160;
            if (wa[i] !== 15'(i) || wd[i] !== px(byte_at(2 * idx), byte_at(2 * idx + 1))) bad++;
        end
        chk("len_addr_data", bad, 0);
        chk("len_le_total", le_cnt, 2);

        // vsync abort at line 50, byte 100
        start_frame();
        clear_log();
        for (int l = 0; l < 50; l++) send_line(320, 1'b1);
        for (int k = 0; k < 100; k++) tick(1'b0, 1'b1, (k % 2 == 0) ? 8'h0F : 8'hF0);
        tick(1'b1, 1'b1, 8'h0F);
        tick(1'b1, 1'b1, 8'hF0);
        tick(1'b1, 1'b0, 8'h00);
        chk("abort_strobes", wa.size(), 8050);
        chk("abort_last_addr", (wa.size() > 0) ? 32'(wa[wa.size() - 1]) : 32'hFFFF, 8049);
        chk("abort_le", le_cnt, 1);
        chk("abort_fd", fd_cnt, 1);
        clear_log();
        tick(1'b0, 1'b0, 8'h00);
        send_line(4, 1'b0);
        chk("restart_strobes", wa.size(), 2);
        chk("restart_addr0", (wa.size() > 0) ? 32'(wa[0]) : 32'hFFFF, 0);

        // Reset at pixel 500, mid-pixel
        start_frame();
        clear_log();
        for (int l = 0; l < 3; l++) send_line(320, 1'b0);
        for (int k = 0; k < 41; k++) tick(1'b0, 1'b1, byte_at(k));
        chk("pre_reset_addr", DP_RAM_addr_in, 15'd499);
        rst = 1'b0;
        #1;
        chk("async_reset_outputs",
            {DP_RAM_regW, DP_RAM_addr_in, DP_RAM_data_in, frame_done, line_err}, 32'd0);
        tick(1'b0, 1'b1, 8'h33);
        rst = 1'b1;
        clear_log();
        for (int k = 0; k < 10; k++) tick(1'b0, 1'b1, byte_at(k));
        tick(1'b0, 1'b0, 8'h00);
        chk("post_reset_no_write", wa.size(), 0);
        start_frame();
        chk("post_reset_no_fd", fd_cnt, 0);
        send_line(4, 1'b0);
        chk("post_reset_addr0", (wa.size() > 0) ? 32'(wa[0]) : 32'hFFFF, 0);
        chk("post_reset_data0", (wa.size() > 0) ? 32'(wd[0]) : 32'hFFFF,
            32'(px(byte_at(0), byte_at(1))));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
